// File: rtl/bcd_pkg.sv
// Shared types and codes for the sequential binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LATCH
    } state_t;

    typedef logic [3:0] digit_t;

    // The 7-segment decoder blanks on 4'hA and renders 4'hF as "F".
    localparam digit_t BLANK_CODE = 4'hA;
    localparam digit_t OVF_CODE   = 4'hF;

endpackage

// File: rtl/bcd_add3.sv
// Single-digit double-dabble correction: add 3 when the digit is 5 or more.
import bcd_pkg::*;

module bcd_add3 (
    input  logic [3:0] dig_i,
    output logic [3:0] dig_o
);

    assign dig_o = (dig_i >= 4'd5) ? dig_i + 4'd3 : dig_i;

endmodule

// File: rtl/bin2bcd_latch.sv
// Shift-add-3 binary-to-BCD converter, one bit per clock, latched outputs.
// Optional macro LEADING_ZERO_BLANK_EN blanks digits above the top nonzero one.
import bcd_pkg::*;

module bin2bcd_latch #(
    parameter int BIN_W  = 27,
    parameter int DIGITS = 8
) (
    input  logic                iCLK,
    input  logic                iRST,
    input  logic                iStart,
    input  logic [BIN_W-1:0]    iBin,
    output logic                oBusy,
    output logic                oDone,
    output logic [4*DIGITS-1:0] oBCD,
    output logic                oOverflow
);

    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int BCD_W = 4 * DIGITS;

    state_t             state_q, state_d;
    logic [BIN_W-1:0]   sh_q, sh_d;
    logic [BCD_W-1:0]   scr_q, scr_d;
    logic               ovf_q, ovf_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               ovfo_q, ovfo_d;
    logic               done_q, done_d;
    logic [BCD_W-1:0]   corr;
    logic [BCD_W-1:0]   latch_val;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_add3
            bcd_add3 u_add3 (
                .dig_i (scr_q[4*g +: 4]),
                .dig_o (corr[4*g +: 4])
            );
        end
    endgenerate

`ifdef LEADING_ZERO_BLANK_EN
    logic lead;

    always_comb begin
        lead      = 1'b1;
        latch_val = scr_q;
        // Digit 0 is excluded so a zero value still shows one "0".
        for (int i = DIGITS - 1; i > 0; i--) begin
            if (lead && (scr_q[4*i +: 4] == 4'd0)) begin
                latch_val[4*i +: 4] = BLANK_CODE;
            end else begin
                lead = 1'b0;
            end
        end
        if (ovf_q) begin
            latch_val = {DIGITS{OVF_CODE}};
        end
    end
`else
    always_comb begin
        latch_val = ovf_q ? {DIGITS{OVF_CODE}} : scr_q;
    end
`endif

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        scr_d   = scr_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        ovfo_d  = ovfo_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (iStart) begin
                    sh_d    = iBin;
                    scr_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                scr_d = {corr[BCD_W-2:0], sh_q[BIN_W-1]};
                sh_d  = {sh_q[BIN_W-2:0], 1'b0};
                // A bit falling off the top digit means the value is too big.
                ovf_d = ovf_q | corr[BCD_W-1];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(BIN_W - 1)) begin
                    state_d = LATCH;
                end
            end
            LATCH: begin
                bcd_d   = latch_val;
                ovfo_d  = ovf_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q <= IDLE;
            sh_q    <= '0;
            scr_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            ovfo_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            scr_q   <= scr_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            ovfo_q  <= ovfo_d;
            done_q  <= done_d;
        end
    end

    assign oBusy     = (state_q != IDLE);
    assign oDone     = done_q;
    assign oBCD      = bcd_q;
    assign oOverflow = ovfo_q;

endmodule
